// File: rtl/roce_stack_dm_status_tracker_pkg.sv
// Shared types for the datamover status tracker: status byte layout,
// drain FSM encoding and the status error decode.
package roce_stack_dm_status_tracker_pkg;

    typedef struct packed {
        logic       okay;
        logic       slverr;
        logic       decerr;
        logic       interr;
        logic [3:0] tag;
    } dm_sts_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } dm_drain_state_t;

    // SLVERR, DECERR and INTERR positions within the status byte
    localparam logic [7:0] StsErrMask = 8'h70;

    function automatic logic sts_is_err(input dm_sts_t sts);
        return !sts.okay || ((sts & StsErrMask) != 8'h00);
    endfunction

endpackage

// File: rtl/roce_stack_dm_sts_channel.sv
// One datamover direction: outstanding-command counter, error counter,
// sticky error flag, last error status byte and protocol-fault flag.
module roce_stack_dm_sts_channel
    import roce_stack_dm_status_tracker_pkg::*;
#(
    parameter int unsigned OUTST_W  = 6,
    parameter int unsigned ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_fire,
    input  logic                sts_valid,
    input  logic [7:0]          sts_data,
    input  logic                err_clr,
    output logic [OUTST_W-1:0]  outst,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                err,
    output logic [7:0]          last_err_sts,
    output logic                proto_err
);

    localparam logic [OUTST_W-1:0]  OutstMax = '1;
    localparam logic [OUTST_W-1:0]  OutstOne = OUTST_W'(1);
    localparam logic [ERRCNT_W-1:0] ErrMax   = '1;
    localparam logic [ERRCNT_W-1:0] ErrOne   = ERRCNT_W'(1);

    logic [OUTST_W-1:0]  outst_q, outst_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                err_q, err_d;
    logic [7:0]          last_q, last_d;
    logic                proto_q, proto_d;
    logic                fault;
    logic                is_err;

    assign is_err = sts_valid && sts_is_err(dm_sts_t'(sts_data));

    always_comb begin
        outst_d = outst_q;
        fault   = 1'b0;
        // A command and a status in the same cycle cancel out, even at the limits
        if (cmd_fire && !sts_valid) begin
            if (outst_q == OutstMax) fault = 1'b1;
            else                     outst_d = outst_q + OutstOne;
        end else if (sts_valid && !cmd_fire) begin
            if (outst_q == '0) fault = 1'b1;
            else               outst_d = outst_q - OutstOne;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        err_d     = err_q;
        last_d    = last_q;
        proto_d   = proto_q | fault;
        if (err_clr) begin
            err_cnt_d = is_err ? ErrOne : '0;
            err_d     = is_err;
            last_d    = is_err ? sts_data : 8'h00;
            proto_d   = fault;
        end else if (is_err) begin
            if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ErrOne;
            err_d  = 1'b1;
            last_d = sts_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q   <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            last_q    <= 8'h00;
            proto_q   <= 1'b0;
        end else begin
            outst_q   <= outst_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            last_q    <= last_d;
            proto_q   <= proto_d;
        end
    end

    assign outst        = outst_q;
    assign err_cnt      = err_cnt_q;
    assign err          = err_q;
    assign last_err_sts = last_q;
    assign proto_err    = proto_q;

endmodule

// File: rtl/roce_stack_dm_status_tracker.sv
// Tracks datamover read/write command/status traffic, raises command
// back-pressure near counter saturation and runs the drain handshake.
module roce_stack_dm_status_tracker
    import roce_stack_dm_status_tracker_pkg::*;
#(
    parameter int unsigned OUTST_W  = 6,
    parameter int unsigned ERRCNT_W = 16
) (
    input  logic                axis_aclk_i,
    input  logic                aresetn_i,
    input  logic                mm2s_cmd_valid_i,
    input  logic                mm2s_cmd_ready_i,
    input  logic                s2mm_cmd_valid_i,
    input  logic                s2mm_cmd_ready_i,
    input  logic [7:0]          mm2s_sts_tdata_i,
    input  logic                mm2s_sts_tvalid_i,
    output logic                mm2s_sts_tready_o,
    input  logic [7:0]          s2mm_sts_tdata_i,
    input  logic                s2mm_sts_tvalid_i,
    output logic                s2mm_sts_tready_o,
    output logic                cmd_block_o,
    input  logic                drain_req_i,
    output logic                drain_done_o,
    input  logic                err_clr_i,
    output logic [OUTST_W-1:0]  rd_outst_o,
    output logic [OUTST_W-1:0]  wr_outst_o,
    output logic [ERRCNT_W-1:0] rd_err_cnt_o,
    output logic [ERRCNT_W-1:0] wr_err_cnt_o,
    output logic                rd_err_o,
    output logic                wr_err_o,
    output logic [7:0]          rd_last_err_sts_o,
    output logic [7:0]          wr_last_err_sts_o,
    output logic                proto_err_o
);

    // Block one below all-ones so a command already in flight still fits
    localparam logic [OUTST_W-1:0] BlockLevel = {{(OUTST_W-1){1'b1}}, 1'b0};

    dm_drain_state_t state_q, state_d;
    logic            cmd_block_q;
    logic            tready_q;
    logic            rd_proto, wr_proto;

    roce_stack_dm_sts_channel #(
        .OUTST_W  (OUTST_W),
        .ERRCNT_W (ERRCNT_W)
    ) u_mm2s (
        .clk          (axis_aclk_i),
        .rst_n        (aresetn_i),
        .cmd_fire     (mm2s_cmd_valid_i && mm2s_cmd_ready_i),
        .sts_valid    (mm2s_sts_tvalid_i),
        .sts_data     (mm2s_sts_tdata_i),
        .err_clr      (err_clr_i),
        .outst        (rd_outst_o),
        .err_cnt      (rd_err_cnt_o),
        .err          (rd_err_o),
        .last_err_sts (rd_last_err_sts_o),
        .proto_err    (rd_proto)
    );

    roce_stack_dm_sts_channel #(
        .OUTST_W  (OUTST_W),
        .ERRCNT_W (ERRCNT_W)
    ) u_s2mm (
        .clk          (axis_aclk_i),
        .rst_n        (aresetn_i),
        .cmd_fire     (s2mm_cmd_valid_i && s2mm_cmd_ready_i),
        .sts_valid    (s2mm_sts_tvalid_i),
        .sts_data     (s2mm_sts_tdata_i),
        .err_clr      (err_clr_i),
        .outst        (wr_outst_o),
        .err_cnt      (wr_err_cnt_o),
        .err          (wr_err_o),
        .last_err_sts (wr_last_err_sts_o),
        .proto_err    (wr_proto)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (drain_req_i) state_d = StDrain;
            StDrain: begin
                if (!drain_req_i)                                  state_d = StIdle;
                else if (rd_outst_o == '0 && wr_outst_o == '0)     state_d = StDone;
            end
            StDone:  if (!drain_req_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q     <= StIdle;
            cmd_block_q <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_block_q <= (rd_outst_o >= BlockLevel) || (wr_outst_o >= BlockLevel)
                           || (state_q != StIdle);
            tready_q    <= 1'b1;
        end
    end

    assign cmd_block_o       = cmd_block_q;
    assign drain_done_o      = (state_q == StDone);
    assign mm2s_sts_tready_o = tready_q;
    assign s2mm_sts_tready_o = tready_q;
    assign proto_err_o       = rd_proto | wr_proto;

endmodule

// File: tb/tb_roce_stack_dm_status_tracker.sv
// Scoreboard bench: directed scenarios plus random traffic against a
// counting reference model of the status tracker.
module tb_roce_stack_dm_status_tracker;

    localparam int OW   = 6;
    localparam int EW   = 16;
    localparam int OMAX = (1 << OW) - 1;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rc_v, rc_r, wc_v, wc_r;
    logic [7:0]    rs_d, ws_d;
    logic          rs_v, ws_v;
    logic          rs_rdy, ws_rdy;
    logic          blk, drn, done, clr;
    logic [OW-1:0] rd_o, wr_o;
    logic [EW-1:0] rd_ec, wr_ec;
    logic          rd_e, wr_e, proto;
    logic [7:0]    rd_l, wr_l;

    always #5 clk = ~clk;

    roce_stack_dm_status_tracker #(.OUTST_W(OW), .ERRCNT_W(EW)) dut (
        .axis_aclk_i       (clk),
        .aresetn_i         (rst_n),
        .mm2s_cmd_valid_i  (rc_v),
        .mm2s_cmd_ready_i  (rc_r),
        .s2mm_cmd_valid_i  (wc_v),
        .s2mm_cmd_ready_i  (wc_r),
        .mm2s_sts_tdata_i  (rs_d),
        .mm2s_sts_tvalid_i (rs_v),
        .mm2s_sts_tready_o (rs_rdy),
        .s2mm_sts_tdata_i  (ws_d),
        .s2mm_sts_tvalid_i (ws_v),
        .s2mm_sts_tready_o (ws_rdy),
        .cmd_block_o       (blk),
        .drain_req_i       (drn),
        .drain_done_o      (done),
        .err_clr_i         (clr),
        .rd_outst_o        (rd_o),
        .wr_outst_o        (wr_o),
        .rd_err_cnt_o      (rd_ec),
        .wr_err_cnt_o      (wr_ec),
        .rd_err_o          (rd_e),
        .wr_err_o          (wr_e),
        .rd_last_err_sts_o (rd_l),
        .wr_last_err_sts_o (wr_l),
        .proto_err_o       (proto)
    );

    typedef struct {
        int rd_o, wr_o, rd_ec, wr_ec, rd_l, wr_l;
        bit rd_e, wr_e, proto, blk, done, trdy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state; drain phase: 0 idle, 1 draining, 2 done
    int m_rd_o, m_wr_o, m_rd_ec, m_wr_ec, m_rd_l, m_wr_l, m_phase;
    bit m_rd_e, m_wr_e, m_proto, m_blk, m_trdy;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input int b);
        return (b < 128) || ((b & 'h70) != 0);
    endfunction

    task automatic model_reset();
        m_rd_o = 0; m_wr_o = 0; m_rd_ec = 0; m_wr_ec = 0; m_rd_l = 0; m_wr_l = 0;
        m_phase = 0; m_rd_e = 0; m_wr_e = 0; m_proto = 0; m_blk = 0; m_trdy = 0;
    endtask

    task automatic dir_model(input bit cmd, input bit sts, input int data, input bit c,
                             inout int o, inout int ec, inout bit e, inout int l,
                             output bit fault);
        bit ise;
        fault = 0;
        if (cmd && !sts) begin
            if (o == OMAX) fault = 1; else o = o + 1;
        end else if (sts && !cmd) begin
            if (o == 0) fault = 1; else o = o - 1;
        end
        ise = sts && is_err(data);
        if (c) begin
            ec = ise ? 1 : 0; e = ise; l = ise ? data : 0;
        end else if (ise) begin
            ec = (ec < EMAX) ? ec + 1 : ec; e = 1; l = data;
        end
    endtask

    // Drive one cycle of stimulus, advance the model, queue the expected outputs
    task automatic step(input bit rc, input bit wc, input bit rv, input int rd,
                        input bit wv, input int wd, input bit dr, input bit c,
                        input bit rr = 1, input bit wr = 1);
        exp_t e;
        bit   fr, fw;
        int   ph;
        rc_v = rc; rc_r = rr; wc_v = wc; wc_r = wr;
        rs_v = rv; rs_d = 8'(rd); ws_v = wv; ws_d = 8'(wd); drn = dr; clr = c;
        ph = m_phase;
        if (m_phase == 0)      ph = dr ? 1 : 0;
        else if (m_phase == 1) ph = !dr ? 0 : ((m_rd_o == 0 && m_wr_o == 0) ? 2 : 1);
        else                   ph = dr ? 2 : 0;
        m_blk = (m_rd_o >= OMAX - 1) || (m_wr_o >= OMAX - 1) || (m_phase != 0);
        m_phase = ph;
        dir_model(rc && rr, rv, rd, c, m_rd_o, m_rd_ec, m_rd_e, m_rd_l, fr);
        dir_model(wc && wr, wv, wd, c, m_wr_o, m_wr_ec, m_wr_e, m_wr_l, fw);
        m_proto = c ? (fr || fw) : (m_proto || fr || fw);
        m_trdy = 1;
        e.rd_o = m_rd_o; e.wr_o = m_wr_o; e.rd_ec = m_rd_ec; e.wr_ec = m_wr_ec;
        e.rd_l = m_rd_l; e.wr_l = m_wr_l; e.rd_e = m_rd_e; e.wr_e = m_wr_e;
        e.proto = m_proto; e.blk = m_blk; e.done = (m_phase == 2); e.trdy = m_trdy;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit dr = 0);
        repeat (n) step(0, 0, 0, 0, 0, 0, dr, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rd_outst"}, int'(rd_o), 0);
        chk({tag, "_wr_outst"}, int'(wr_o), 0);
        chk({tag, "_rd_err_cnt"}, int'(rd_ec), 0);
        chk({tag, "_wr_err_cnt"}, int'(wr_ec), 0);
        chk({tag, "_flags"}, int'({rd_e, wr_e, proto, blk, done}), 0);
        chk({tag, "_last"}, int'({rd_l, wr_l}), 0);
        chk({tag, "_tready"}, int'({rs_rdy, ws_rdy}), 0);
    endtask

    // Monitor: every cycle the DUT presents fresh outputs, compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_outst", int'(rd_o), e.rd_o);
                chk("wr_outst", int'(wr_o), e.wr_o);
                chk("rd_err_cnt", int'(rd_ec), e.rd_ec);
                chk("wr_err_cnt", int'(wr_ec), e.wr_ec);
                chk("rd_err", int'(rd_e), int'(e.rd_e));
                chk("wr_err", int'(wr_e), int'(e.wr_e));
                chk("rd_last_err", int'(rd_l), e.rd_l);
                chk("wr_last_err", int'(wr_l), e.wr_l);
                chk("proto_err", int'(proto), int'(e.proto));
                chk("cmd_block", int'(blk), int'(e.blk));
                chk("drain_done", int'(done), int'(e.done));
                chk("sts_tready", int'({rs_rdy, ws_rdy}), e.trdy ? 3 : 0);
            end
        end
    end

    initial begin
        bit rdr;
        rst_n = 0;
        rc_v = 0; rc_r = 0; wc_v = 0; wc_r = 0; rs_v = 0; ws_v = 0;
        rs_d = 0; ws_d = 0; drn = 0; clr = 0;
        model_reset();
        #1;
        reset_checks("por");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
        idle(1);

        // Three reads then three OK statuses
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 'h80, 0, 0, 0, 0);

        // SLVERR write status, then clear
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 'hC1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Underflow, clear, then cmd+sts in the same cycle at 5
        step(0, 0, 1, 'h80, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 'h85, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 'h80, 0, 0, 0, 0);

        // Drain with 2 reads outstanding
        idle(4, 1);
        step(0, 0, 1, 'h81, 0, 0, 1, 0);
        idle(1, 1);
        step(0, 0, 1, 'h82, 0, 0, 1, 0);
        idle(3, 1);
        idle(3, 0);
        // Drain aborted while commands are outstanding
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3, 1);
        idle(2, 0);
        step(0, 0, 0, 0, 1, 'h80, 0, 0);
        // Drain with nothing outstanding
        idle(4, 1);
        idle(2, 0);

        // Fill reads toward saturation, clear coincident with an error status
        repeat (62) step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 'h90, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 'h40, 0, 0, 0, 0);
        while (m_rd_o > 4) step(0, 0, 1, 'h80, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 'h20, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle with traffic present
        #1;
        rst_n = 0;
        rc_v = 1; rc_r = 1; rs_v = 1; rs_d = 8'h00; ws_v = 1; ws_d = 8'h00; drn = 1;
        #1;
        reset_checks("arst");
        @(posedge clk);
        #1;
        reset_checks("arst_hold");
        @(posedge clk);
        #2;
        rc_v = 0; rs_v = 0; ws_v = 0; drn = 0;
        model_reset();
        rst_n = 1;
        idle(2);

        // Random traffic
        rdr = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rc, wc, rv, wv, c;
            int rd, wd;
            if ($urandom_range(0, 29) == 0) rdr = ~rdr;
            rc = ($urandom_range(0, 2) == 0);
            wc = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 2) == 0);
            wv = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'('h80 | $urandom_range(0, 15));
            wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'('h80 | $urandom_range(0, 15));
            c = ($urandom_range(0, 39) == 0);
            step(rc, wc, rv, rd, wv, wd, rdr, c, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(2);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
